score_display_driver: RTL and testbench
=======================================

// Module: score_display_driver
// PURPOSE
//  Consumer end of the score counter's BCD interface: latches bcd_tens/bcd_ones, multiplexes them onto a
//  2-digit common-segment 7-seg display with anti-ghost blanking, leading-zero blanking, game-state effects.
//  Sits between score_counter and the top-level display pins. Single clk domain (12 MHz).
// PARAMETERS
//  SCAN_DIV   12000     clk cycles per digit slot (1 kHz per digit at 12 MHz)
//  GUARD_CYC  120       clk cycles all digits off between slots (anti-ghosting); must be < SCAN_DIV
//  BLINK_DIV  3000000   clk cycles per blink half-period in OVER (2 Hz toggle)
// PORTS
//  clk       in   1  system clock
//  reset     in   1  asynchronous, active-low reset
//  state     in   state_t  game state (IDLE/RUN/WIN/OVER) from game_pkg
//  bcd_tens  in   4  tens digit from score_counter
//  bcd_ones  in   4  ones digit from score_counter
//  seg       out  7  segments {g,f,e,d,c,b,a}, active-high
//  dp        out  1  decimal point, active-high
//  digit_en  out  2  one-hot digit select, [1]=tens [0]=ones, active-high
//  frame_p   out  1  1-cycle pulse when latched digits update (start of each tens slot)
// BEHAVIOUR
//  Reset: seg=0, dp=0, digit_en=0, frame_p=0; FSM=BLANK_B, scan_cnt=0, latched digits=0, blink_vis=1.
//  Scan FSM: DIG_TENS -> BLANK_A -> DIG_ONES -> BLANK_B -> DIG_TENS.
//   DIG_* last SCAN_DIV-GUARD_CYC cycles; BLANK_* last GUARD_CYC cycles; scan_cnt restarts at each transition.
//   Slot boundaries fall only on terminal count; no other event alters scan timing.
//  Latching: bcd_tens/bcd_ones sampled into lat_tens/lat_ones only on the BLANK_B->DIG_TENS transition;
//   frame_p high that same cycle. Mid-frame input changes never tear a displayed pair.
//  Decode: 0-9 standard (0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F); values 10-15 -> dash 7'h40.
//  Leading-zero blank: lat_tens==0 -> tens slot seg=0 (digit_en still asserted); ones always shown.
//  State effects (sampled each cycle, not latched):
//   IDLE: normal display. RUN: normal. WIN: normal + dp=1 during ones slot only.
//   OVER: blink; blink_cnt counts BLINK_DIV then toggles blink_vis; blink_vis=0 forces seg=0, dp=0.
//   Entry into OVER (state!=OVER -> OVER) clears blink_cnt, sets blink_vis=1 (first half-period visible).
//   Leaving OVER: blink_vis forced 1 next cycle, blink_cnt held at 0.
//   Any other/illegal state value: treated as IDLE.
//  Outputs registered: seg/dp/digit_en reflect FSM state with 1-cycle latency; in BLANK_* all three are 0.
//  digit_en never has both bits set; never overlaps a seg change (seg updates in same cycle as digit_en).
//  Reset mid-frame: immediate return to reset values, scan restarts from BLANK_B; first DIG_TENS after
//   GUARD_CYC cycles with freshly latched inputs.
//  Widths: scan_cnt/blink_cnt sized $clog2 of their divider; compare with >= terminal to be overflow-safe.
// STRUCTURE
//  game_pkg (shared): state_t {IDLE,RUN,WIN,OVER}, SEG_BLANK=7'h00, SEG_DASH=7'h40 constants.
//  Local typedef scan_state_t for the 4-state FSM stays in this module.
//  Sub-module: seven_seg_decoder (combinational 4-bit BCD -> 7-bit seg, dash for >9), one instance muxed by slot.
// TESTING (bench params SCAN_DIV=8, GUARD_CYC=2, BLINK_DIV=32)
//  Reset release, state=RUN, tens=4 ones=2 -> after 2 cycles digit_en=10 seg=66 for 6 cycles, 00 for 2,
//   then 01 seg=5B for 6 cycles; frame_p single pulse every 16 cycles.
//  tens=0 ones=7 -> tens slot digit_en=10 seg=00; ones slot seg=07.
//  Change ones 2->3 mid-DIG_ONES -> displayed ones stays 5B until after next frame_p, then 4F.
//  tens=4'hB -> tens slot seg=40 (dash); ones unaffected.
//  state=WIN, 99 -> dp=1 only while digit_en=01; state=OVER -> 32 cycles normal, 32 blank, repeat;
//   re-enter OVER mid-blank -> visible immediately.
//  Assert reset during DIG_ONES -> all outputs 0 next edge; after release digit_en=10 exactly 2+1 cycles later.
//  Continuous checks: digit_en never 11; seg/dp=0 whenever digit_en=00.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-level types and 7-segment constants.
// Used by the score datapath and the display driver.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD to 7-segment decoder, segments {g,f,e,d,c,b,a} active-high.
// Non-decimal codes 10-15 render as a dash.
module seven_seg_decoder
    import game_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup; anything outside 0-9 falls through to the dash.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = 7'h3F;
            4'd1: seg_o = 7'h06;
            4'd2: seg_o = 7'h5B;
            4'd3: seg_o = 7'h4F;
            4'd4: seg_o = 7'h66;
            4'd5: seg_o = 7'h6D;
            4'd6: seg_o = 7'h7D;
            4'd7: seg_o = 7'h07;
            4'd8: seg_o = 7'h7F;
            4'd9: seg_o = 7'h6F;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display_driver.sv
// Two-digit multiplexed 7-seg driver for the score counter.
// Guard-blanked scan, frame-latched digits, WIN dp and OVER blink.
module score_display_driver
    import game_pkg::*;
#(
    parameter int SCAN_DIV  = 12000,
    parameter int GUARD_CYC = 120,
    parameter int BLINK_DIV = 3000000
) (
    input  logic       clk,
    input  logic       reset,
    input  state_t     state,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_en,
    output logic       frame_p
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] DIG_LAST = SW'(SCAN_DIV - GUARD_CYC - 1);
    localparam logic [SW-1:0] GRD_LAST = SW'(GUARD_CYC - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        DIG_TENS = 2'd0,
        BLANK_A  = 2'd1,
        DIG_ONES = 2'd2,
        BLANK_B  = 2'd3
    } scan_state_t;

    scan_state_t   scan_q, scan_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [3:0]    lat_tens_q, lat_tens_d;
    logic [3:0]    lat_ones_q, lat_ones_d;
    logic          frame_q, frame_d;
    logic          slot_last;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_vis_q, blink_vis_d;

    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [1:0]    en_q, en_d;

    logic          is_over;
    logic          is_win;
    logic          show;
    logic [3:0]    dec_in;
    logic [6:0]    dec_seg;

    // Unknown game states simply get normal display.
    assign is_over = (state == OVER);
    assign is_win  = (state == WIN);
    assign show    = !is_over || blink_vis_q;

    assign dec_in = (scan_q == DIG_TENS) ? lat_tens_q : lat_ones_q;

    seven_seg_decoder u_dec (
        .bcd_i (dec_in),
        .seg_o (dec_seg)
    );

    // Scan sequencing; digits are latched only at the start of a frame.
    always_comb begin
        scan_d     = scan_q;
        scan_cnt_d = scan_cnt_q + SW'(1);
        lat_tens_d = lat_tens_q;
        lat_ones_d = lat_ones_q;
        frame_d    = 1'b0;
        slot_last  = 1'b0;
        if (scan_q == DIG_TENS || scan_q == DIG_ONES) begin
            slot_last = (scan_cnt_q >= DIG_LAST);
        end else begin
            slot_last = (scan_cnt_q >= GRD_LAST);
        end
        if (slot_last) begin
            scan_cnt_d = '0;
            unique case (scan_q)
                DIG_TENS: scan_d = BLANK_A;
                BLANK_A:  scan_d = DIG_ONES;
                DIG_ONES: scan_d = BLANK_B;
                BLANK_B: begin
                    scan_d     = DIG_TENS;
                    lat_tens_d = bcd_tens;
                    lat_ones_d = bcd_ones;
                    frame_d    = 1'b1;
                end
            endcase
        end
    end

    // Blink runs only inside OVER; outside it sits at visible, count 0.
    always_comb begin
        blink_cnt_d = '0;
        blink_vis_d = 1'b1;
        if (is_over) begin
            if (blink_cnt_q >= BLK_LAST) begin
                blink_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_vis_d = blink_vis_q;
            end
        end
    end

    // Next display outputs from the current slot; guard slots stay dark.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        en_d  = 2'b00;
        unique case (scan_q)
            DIG_TENS: begin
                en_d  = 2'b10;
                seg_d = (lat_tens_q == 4'd0) ? SEG_BLANK : dec_seg;
            end
            DIG_ONES: begin
                en_d  = 2'b01;
                seg_d = dec_seg;
                dp_d  = is_win;
            end
            BLANK_A, BLANK_B: begin
                en_d = 2'b00;
            end
        endcase
        if (!show) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b0;
        end
    end

    // Scan state, counters and latched digit pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q     <= BLANK_B;
            scan_cnt_q <= '0;
            lat_tens_q <= 4'd0;
            lat_ones_q <= 4'd0;
            frame_q    <= 1'b0;
        end else begin
            scan_q     <= scan_d;
            scan_cnt_q <= scan_cnt_d;
            lat_tens_q <= lat_tens_d;
            lat_ones_q <= lat_ones_d;
            frame_q    <= frame_d;
        end
    end

    // Blink half-period timer and visibility flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
        end
    end

    // Registered pins so seg and digit_en always change together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b0;
            en_q  <= 2'b00;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            en_q  <= en_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign digit_en = en_q;
    assign frame_p  = frame_q;

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver.
// Reference model works from frame position and OVER dwell time.
module tb_score_display_driver;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    state_t     state;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_en;
    logic       frame_p;

    always #5 clk = ~clk;

    score_display_driver #(
        .SCAN_DIV  (8),
        .GUARD_CYC (2),
        .BLINK_DIV (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .state    (state),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .seg      (seg),
        .dp       (dp),
        .digit_en (digit_en),
        .frame_p  (frame_p)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: edges since reset release, frame-latched pair, OVER dwell.
    int         k      = 0;
    int         n_over = 0;
    logic [3:0] m_tens = 4'd0;
    logic [3:0] m_ones = 4'd0;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [1:0] e_en;
    logic       e_fp;

    function automatic logic [6:0] ref_dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the inputs present before the edge, then compare.
    task automatic tick();
        int     opos;
        int     fpos;
        logic   vis;
        state_t s;
        s = state;
        if (!reset) begin
            k      = 0;
            n_over = 0;
            m_tens = 4'd0;
            m_ones = 4'd0;
            e_seg  = 7'h00;
            e_dp   = 1'b0;
            e_en   = 2'b00;
            e_fp   = 1'b0;
        end else begin
            k++;
            n_over = (s == OVER) ? n_over + 1 : 0;
            vis    = (s != OVER) || ((((n_over - 1) / 32) % 2) == 0);
            opos   = (13 + k) % 16;
            fpos   = (14 + k) % 16;
            e_seg  = 7'h00;
            e_dp   = 1'b0;
            e_en   = 2'b00;
            if (opos <= 5) begin
                e_en  = 2'b10;
                e_seg = (m_tens == 4'd0) ? 7'h00 : ref_dec(m_tens);
            end else if (opos >= 8 && opos <= 13) begin
                e_en  = 2'b01;
                e_seg = ref_dec(m_ones);
                e_dp  = (s == WIN);
            end
            if (!vis) begin
                e_seg = 7'h00;
                e_dp  = 1'b0;
            end
            e_fp = (fpos == 0);
            if (fpos == 0) begin
                m_tens = bcd_tens;
                m_ones = bcd_ones;
            end
        end
        @(posedge clk);
        #1;
        chk("seg", 8'(seg), 8'(e_seg));
        chk("dp", 8'(dp), 8'(e_dp));
        chk("digit_en", 8'(digit_en), 8'(e_en));
        chk("frame_p", 8'(frame_p), 8'(e_fp));
        chk("en_not_both", 8'(digit_en != 2'b11), 8'd1);
        chk("dark_when_off",
            8'((digit_en != 2'b00) || (seg == 7'h00 && dp == 1'b0)), 8'd1);
    endtask

    initial begin
        int guard;
        reset    = 1'b0;
        state    = RUN;
        bcd_tens = 4'd4;
        bcd_ones = 4'd2;

        repeat (2) tick();
        reset = 1'b1;

        repeat (3) tick();
        chk("first_tens_en", 8'(digit_en), 8'h02);
        chk("first_tens_seg", 8'(seg), 8'h66);
        repeat (45) tick();

        bcd_tens = 4'd0;
        bcd_ones = 4'd7;
        repeat (32) tick();

        bcd_tens = 4'd4;
        bcd_ones = 4'd2;
        repeat (27) tick();
        bcd_ones = 4'd3;
        repeat (40) tick();

        bcd_tens = 4'hB;
        repeat (32) tick();

        state    = WIN;
        bcd_tens = 4'd9;
        bcd_ones = 4'd9;
        repeat (32) tick();

        state = OVER;
        repeat (140) tick();
        state = RUN;
        tick();
        state = OVER;
        repeat (40) tick();
        state = IDLE;
        tick();
        state = OVER;
        repeat (40) tick();

        state = RUN;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) bcd_tens = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bcd_ones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) state = state_t'(2'($urandom_range(0, 3)));
            tick();
        end

        state = RUN;
        guard = 0;
        while (digit_en != 2'b01 && guard < 20) begin
            tick();
            guard++;
        end
        chk("reach_ones", 8'(guard < 20), 8'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("async_seg", 8'(seg), 8'h00);
        chk("async_en", 8'(digit_en), 8'h00);
        chk("async_dp", 8'(dp), 8'h00);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("restart_en", 8'(digit_en), 8'h02);
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
